// File: rtl/data_buff_pkg.sv
// Shared FSM encoding and default parameters for the data-buffer write arbiter.
package data_buff_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ     = 3;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_TIMEOUT_CYC = 255;
    localparam int DEF_LEN_WIDTH   = 12;
    localparam int STALL_W         = 16;

endpackage

// File: rtl/data_buff_rr_pick.sv
// Round-robin pick: one-hot grant for the first set request at or after ptr.
module data_buff_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] gnt_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   gnt_rot;

    // Rotate so ptr sits at bit 0; the upper half of each doubled vector is a
    // subset (or the wrapped remainder) of the other, so OR-ing the halves is exact.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0] | req_dbl[2*NUM_REQ-1:NUM_REQ];
    assign gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
    assign gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    assign gnt     = gnt_dbl[2*NUM_REQ-1:NUM_REQ] | gnt_dbl[NUM_REQ-1:0];

endmodule

// File: rtl/data_buff_wr_arb.sv
// Packet-granular round-robin arbiter merging byte-stream requesters into one FIFO write port,
// with per-packet beat count and mid-packet stall timeout.
module data_buff_wr_arb
    import data_buff_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ-1:0]            s_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_vld,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          pkt_done,
    output logic [LEN_WIDTH-1:0]          pkt_len,
    output logic [NUM_REQ-1:0]            timeout_err,
    input  logic                          err_clr
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e           state, state_nxt;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   pick;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_nxt;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [LEN_WIDTH-1:0] beat_nxt;
    logic [STALL_W-1:0]   stall_cnt;
    logic                 in_xfer;
    logic                 g_valid;
    logic                 g_last;
    logic                 accept;
    logic                 tmo;
    logic                 pkt_end;

    data_buff_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req (s_valid),
        .ptr (ptr),
        .gnt (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    assign in_xfer  = (state == ST_XFER);
    assign g_valid  = s_valid[gnt_idx];
    assign g_last   = s_last[gnt_idx];
    assign accept   = in_xfer & g_valid & fifo_wr_vld;
    assign tmo      = in_xfer & ~g_valid & (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
    assign pkt_end  = (accept & g_last) | tmo;
    assign beat_nxt = (accept && beat_cnt != '1) ? beat_cnt + LEN_WIDTH'(1) : beat_cnt;
    assign ptr_nxt  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    assign gnt          = gnt_q;
    assign s_ready      = in_xfer ? (gnt_q & {NUM_REQ{fifo_wr_vld}}) : '0;
    assign fifo_wr_en   = accept;
    assign fifo_wr_data = s_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|s_valid) state_nxt = ST_XFER;
            ST_XFER: if (pkt_end)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            gnt_idx     <= '0;
            ptr         <= '0;
            beat_cnt    <= '0;
            stall_cnt   <= '0;
            pkt_done    <= 1'b0;
            pkt_len     <= '0;
            timeout_err <= '0;
        end else begin
            pkt_done    <= pkt_end;
            // A timeout landing with err_clr keeps its flag set.
            timeout_err <= (timeout_err & ~{NUM_REQ{err_clr}}) | ({NUM_REQ{tmo}} & gnt_q);
            if (pkt_end) pkt_len <= beat_nxt;

            if (!in_xfer) begin
                if (|s_valid) begin
                    gnt_q     <= pick;
                    gnt_idx   <= pick_idx;
                    beat_cnt  <= '0;
                    stall_cnt <= '0;
                end
            end else begin
                beat_cnt  <= beat_nxt;
                stall_cnt <= g_valid ? '0 : stall_cnt + STALL_W'(1);
                if (pkt_end) begin
                    gnt_q <= '0;
                    ptr   <= ptr_nxt;
                end
            end
        end
    end

endmodule
